// File: rtl/twiddle_apply_seq.sv
// twiddle_apply_seq
// Consumer side of the 16-point FFT twiddle ROM. For each sample of a 16-sample
// frame it produces the twiddle index k for the radix-2 DIF stage being processed.
// It takes the Q1.14 twiddle that the external combinational ROM returns in the same
// cycle, multiplies the sample by it, and streams the rotated sample out.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   stage_sel[1:0]       DIF stage, taken at the first accepted sample of a frame
//   in_valid/in_ready    input handshake; in_re/in_im signed input sample
//   k[2:0]               twiddle index to the ROM (combinational)
//   tw_re/tw_im          Q1.14 twiddle returned by the ROM for the current k
//   out_valid/out_ready  output handshake
//   out_re/out_im        rotated sample, rounded and saturated
//   out_idx[3:0]         frame position of the output sample
//   out_last             high with frame position 15
module twiddle_apply_seq #(
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               stage_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic [2:0]               k,
    input  logic signed [DATA_W-1:0] tw_re,
    input  logic signed [DATA_W-1:0] tw_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [3:0]               out_idx,
    output logic                     out_last
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] RND_C = SUM_W'(1) <<< (TW_FRAC - 1);

    // Saturate a rounded, shifted sum to the signed 16-bit output range
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [SUM_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > 33'sd32767) begin
            r = 16'sh7fff;
        end else if (v < -33'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    // Frame counter and latched stage
    logic [3:0] n_cnt_r;
    logic [1:0] active_r;

    // P1 registers
    logic                     v1_r;
    logic signed [DATA_W-1:0] x_re_r, x_im_r, w_re_r, w_im_r;
    logic [3:0]               n1_r;

    // P2 registers
    logic                     v2_r;
    logic signed [PROD_W-1:0] p_rr_r, p_ii_r, p_ri_r, p_ir_r;
    logic [3:0]               n2_r;

    // Combinational helpers
    logic                     en_s;
    logic [1:0]               cur_stage_s;
    logic [2:0]               k_s;
    logic signed [SUM_W-1:0]  re_sum_s, im_sum_s, re_sh_s, im_sh_s;

    // Global pipeline enable: the whole pipe freezes while output is blocked
    always_comb begin
        en_s = !(out_valid && !out_ready);
    end

    assign in_ready = en_s;
    assign k        = k_s;

    // Twiddle index: k = (p - H) << s in the upper half of each group, else 0.
    // At frame start the live stage_sel is used so the first sample's k is right.
    always_comb begin
        cur_stage_s = (n_cnt_r == 4'd0) ? stage_sel : active_r;
        k_s = 3'd0;
        case (cur_stage_s)
            2'd0:    k_s = n_cnt_r[3] ? n_cnt_r[2:0] : 3'd0;
            2'd1:    k_s = n_cnt_r[2] ? {n_cnt_r[1:0], 1'b0} : 3'd0;
            2'd2:    k_s = n_cnt_r[1] ? {n_cnt_r[0], 2'b00} : 3'd0;
            2'd3:    k_s = 3'd0;
            default: k_s = 3'd0;
        endcase
    end

    // Complex combine of the products, round-half-up and scale back to Q0
    always_comb begin
        re_sum_s = $signed({p_rr_r[PROD_W-1], p_rr_r}) - $signed({p_ii_r[PROD_W-1], p_ii_r});
        im_sum_s = $signed({p_ri_r[PROD_W-1], p_ri_r}) + $signed({p_ir_r[PROD_W-1], p_ir_r});
        re_sh_s  = (re_sum_s + RND_C) >>> TW_FRAC;
        im_sh_s  = (im_sum_s + RND_C) >>> TW_FRAC;
    end

    // Frame counter, stage latch and the three pipeline stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cnt_r   <= 4'd0;
            active_r  <= 2'd0;
            v1_r      <= 1'b0;
            x_re_r    <= '0;
            x_im_r    <= '0;
            w_re_r    <= '0;
            w_im_r    <= '0;
            n1_r      <= 4'd0;
            v2_r      <= 1'b0;
            p_rr_r    <= '0;
            p_ii_r    <= '0;
            p_ri_r    <= '0;
            p_ir_r    <= '0;
            n2_r      <= 4'd0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
        end else if (en_s) begin
            // P1: capture sample and the ROM answer for this sample's k
            v1_r <= in_valid;
            if (in_valid) begin
                x_re_r  <= in_re;
                x_im_r  <= in_im;
                w_re_r  <= tw_re;
                w_im_r  <= tw_im;
                n1_r    <= n_cnt_r;
                n_cnt_r <= n_cnt_r + 4'd1;
                if (n_cnt_r == 4'd0) begin
                    active_r <= stage_sel;
                end
            end
            // P2: four real products
            v2_r <= v1_r;
            if (v1_r) begin
                p_rr_r <= PROD_W'(x_re_r) * PROD_W'(w_re_r);
                p_ii_r <= PROD_W'(x_im_r) * PROD_W'(w_im_r);
                p_ri_r <= PROD_W'(x_re_r) * PROD_W'(w_im_r);
                p_ir_r <= PROD_W'(x_im_r) * PROD_W'(w_re_r);
                n2_r   <= n1_r;
            end
            // P3: registered output; data only changes with a valid sample
            out_valid <= v2_r;
            if (v2_r) begin
                out_re   <= sat16(re_sh_s);
                out_im   <= sat16(im_sh_s);
                out_idx  <= n2_r;
                out_last <= (n2_r == 4'd15);
            end
        end
    end

endmodule
